// File: rtl/pau_recip_seq.sv
// pau_recip_seq: sequential reciprocal unit for a normalized Q1.15 divisor.
// A seed from an external table is refined by ITERS Newton-Raphson steps
// x' = x * (2 - d*x). One shared 16x17 multiplier forms one product per cycle.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid && ready are both high; the producer holds valid and its payload
// stable until that edge, and ready does not depend on valid.
//
// Optional build macro: PAU_RECIP_ROUND_EN selects round-half-up of the
// refined estimate; left undefined, the estimate is truncated.
module pau_recip_seq #(
   parameter int ITERS = 2,
   parameter int ID_W  = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     in_mant,
   input  logic [ID_W-1:0] in_id,
   output logic [7:0]      rom_addr,
   input  logic [8:0]      rom_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [15:0]     out_recip,
   output logic [ID_W-1:0] out_id,
   output logic            out_err,
   output logic            busy,
   output logic [2:0]      dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEED = 3'd1,
      S_MUL1 = 3'd2,
      S_MUL2 = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] ITERS_L = 3'(ITERS);

`ifdef PAU_RECIP_ROUND_EN
   // Adding half an output LSB before the shift gives round-half-up.
   localparam logic [32:0] ROUND_ADD = 33'h0_0000_4000;
`else
   localparam logic [32:0] ROUND_ADD = 33'h0_0000_0000;
`endif

   state_t          state_q, state_d;
   logic [15:0]     d_q, d_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [15:0]     x_q, x_d;
   logic [16:0]     t_q, t_d;
   logic            err_q, err_d;

   logic [16:0]     e_val;
   logic [16:0]     mul_b;
   logic [32:0]     prod;
   logic [17:0]     q_hi;
   logic [15:0]     x_new;
   logic [2:0]      cnt_inc;

   // Shared multiplier: x*d in MUL1, x*(2 - d*x) in MUL2, plus the Newton update.
   always_comb begin
      e_val = 17'h10000 - t_q;
      mul_b = (state_q == S_MUL2) ? e_val : {1'b0, d_q};
      prod  = 33'(x_q) * 33'(mul_b);
      // q[32:15] (+ q[14] when rounding); anything above 1.0 saturates.
      q_hi  = 18'((prod + ROUND_ADD) >> 15);
      if (q_hi > 18'h08000) begin
         x_new = 16'h8000;
      end else begin
         x_new = q_hi[15:0];
      end
      cnt_inc = {1'b0, cnt_q} + 3'd1;
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      t_d     = t_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               d_d   = in_mant;
               id_d  = in_id;
               cnt_d = 2'd0;
               if (in_mant[15]) begin
                  err_d   = 1'b0;
                  state_d = S_SEED;
               end else begin
                  err_d   = 1'b1;
                  x_d     = 16'h0000;
                  state_d = S_DONE;
               end
            end
         end
         S_SEED: begin
            x_d     = {rom_data, 6'b0};
            state_d = (ITERS_L == 3'd0) ? S_DONE : S_MUL1;
         end
         S_MUL1: begin
            t_d     = prod[31:15];
            state_d = S_MUL2;
         end
         S_MUL2: begin
            x_d     = x_new;
            cnt_d   = cnt_inc[1:0];
            state_d = (cnt_inc < ITERS_L) ? S_MUL1 : S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         d_q     <= 16'h0000;
         id_q    <= '0;
         cnt_q   <= 2'd0;
         x_q     <= 16'h0000;
         t_q     <= 17'h00000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         t_q     <= t_d;
         err_q   <= err_d;
      end
   end

   // Output decode; result fields read as zero outside DONE.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_DONE);
      out_recip = out_valid ? x_q : 16'h0000;
      out_id    = out_valid ? id_q : '0;
      out_err   = out_valid & err_q;
      rom_addr  = d_q[14:7];
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_pau_recip_seq.sv
// Bench for pau_recip_seq: directed corner cases, a stall, a mid-operation
// reset, then randomized operands against a plain-arithmetic reference model.
module tb_pau_recip_seq;

   localparam int ITERS = 2;
   localparam int ID_W  = 3;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [15:0]     in_mant;
   logic [ID_W-1:0] in_id;
   logic [7:0]      rom_addr;
   logic [8:0]      rom_data;
   logic            out_valid;
   logic            out_ready;
   logic [15:0]     out_recip;
   logic [ID_W-1:0] out_id;
   logic            out_err;
   logic            busy;
   logic [2:0]      dbg_state;

   int n_vec;
   int n_err;
   logic [19:0] exp_q[$];

   pau_recip_seq #(.ITERS(ITERS), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mant   (in_mant),
      .in_id     (in_id),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_recip (out_recip),
      .out_id    (out_id),
      .out_err   (out_err),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- seed table: round(512 / (1 + (a + 0.5)/256)) ----------------
   function automatic logic [8:0] seed_of(input logic [7:0] a);
      int den;
      int v;
      den = 513 + 2 * int'(a);
      v   = (262144 + den / 2) / den;
      if (v > 511) v = 511;
      return 9'(v);
   endfunction

   assign rom_data = seed_of(rom_addr);

   // ---------------- reference model ----------------
   function automatic logic [15:0] model_recip(input logic [15:0] d);
      logic [7:0] a;
      longint unsigned x, t, e, q, xn;
      a = d[14:7];
      x = longint'(seed_of(a)) * 64;
      for (int i = 0; i < ITERS; i++) begin
         t = ((longint'(d) * x) >> 15) % 131072;          // d*x, Q2.15
         e = (65536 + 131072 - t) % 131072;               // 2 - d*x, mod 2^17
         q = x * e;
         xn = q >> 15;
`ifdef PAU_RECIP_ROUND_EN
         xn = xn + ((q >> 14) % 2);
`endif
         if (xn > 32768) xn = 32768;
         x = xn;
      end
      return 16'(x);
   endfunction

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check_eq({tag, "_busy"},      32'(busy),      32'd0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_out_err"},   32'(out_err),   32'd0);
      check_eq({tag, "_out_recip"}, 32'(out_recip), 32'd0);
      check_eq({tag, "_out_id"},    32'(out_id),    32'd0);
      check_eq({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
      check_eq({tag, "_state"},     32'(dbg_state), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one operand; returns after the accept edge (sampled #1 later).
   task automatic send(input logic [15:0] d, input logic [ID_W-1:0] id);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      check_eq("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_mant  = d;
      in_id    = id;
      if (d[15]) exp_q.push_back({1'b0, id, model_recip(d)});
      else       exp_q.push_back({1'b1, id, 16'h0000});
      tick();
      in_valid = 1'b0;
      in_mant  = 16'(urand16());
      in_id    = ID_W'($urandom);
      check_eq("rom_addr", 32'(rom_addr), 32'(d[14:7]));
      check_eq("busy_after_accept", 32'(busy), 32'd1);
      check_eq("in_ready_after_accept", 32'(in_ready), 32'd0);
   endtask

   function automatic int urand16();
      return int'($urandom_range(0, 65535));
   endfunction

   // Waits for the result (counting edges after the accept edge), stalls
   // out_ready for `stall` cycles, then completes the handshake.
   task automatic collect(input logic err, input int stall, output logic [15:0] got);
      int lat;
      logic [19:0] exp;
      logic [19:0] held;
      lat = 0;
      got = 16'h0000;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!out_valid) begin
         check_eq("result_timeout", 32'd1, 32'd0);
         void'(exp_q.pop_front());
         return;
      end
      check_eq("latency", 32'(lat), err ? 32'd0 : 32'(1 + 2 * ITERS));
      exp = exp_q.pop_front();
      check_eq("result", 32'({out_err, out_id, out_recip}), 32'(exp));
      got  = out_recip;
      held = {out_err, out_id, out_recip};
      for (int i = 0; i < stall; i++) begin
         tick();
         check_eq("stall_stable", 32'({out_valid, in_ready, out_err, out_id, out_recip}),
                  32'({1'b1, 1'b0, held}));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
      check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] got;
      logic [15:0] d;
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_mant   = 16'h0000;
      in_id     = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // d = 1.0: seed 0x7FC0, two iterations
      send(16'h8000, 3'd5);
      check_eq("rom_addr_8000", 32'(rom_addr), 32'h00);
      collect(1'b0, 0, got);
`ifdef PAU_RECIP_ROUND_EN
      check_eq("recip_8000", 32'(got), 32'h8000);
`else
      check_eq("recip_8000", 32'(got), 32'h7FFF);
`endif

      // d just under 2.0: seed 0x4000 is already exact
      send(16'hFFFF, 3'd6);
      check_eq("rom_addr_ffff", 32'(rom_addr), 32'hFF);
      collect(1'b0, 0, got);
      check_eq("recip_ffff", 32'(got), 32'h4000);

      // non-normalized operand: error result one cycle on, tag echoed
      send(16'h4000, 3'd3);
      collect(1'b1, 0, got);
      check_eq("err_recip", 32'(got), 32'h0000);

      // result held across a 10-cycle out_ready stall
      send(16'hC000, 3'd1);
      collect(1'b0, 10, got);

      // reset in the middle of an operation
      send(16'h9000, 3'd2);
      tick();                       // SEED -> MUL1
      tick();                       // MUL1 -> MUL2
      check_eq("mid_state_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      void'(exp_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("no_result_after_reset", 32'(out_valid), 32'd0);
      end
      send(16'hB5A3, 3'd4);
      check_eq("rom_addr_b5a3", 32'(rom_addr), 32'h6B);
      collect(1'b0, 0, got);

      // randomized operands, occasional non-normalized and stalls
      for (int n = 0; n < 40; n++) begin
         d = 16'(urand16());
         if ($urandom_range(0, 7) != 0) d[15] = 1'b1;
         send(d, ID_W'($urandom));
         collect(~d[15], int'($urandom_range(0, 3)), got);
         repeat ($urandom_range(0, 2)) tick();
      end

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time guard
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pau_recip_seq.md
PAU_RECIP_SEQ -- requirements
Module: pau_recip_seq

Interface
REQ-001 Parameter ITERS, default 2, number of Newton-Raphson iterations SHALL be in the range 0..3.
REQ-002 Parameter ID_W, default 3, SHALL set the width of the transaction tag.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  SHALL form the operand handshake.
REQ-006 in_mant  in  16  SHALL carry the divisor d, unsigned Q1.15, normalized so d is in [1,2) with bit15=1.
REQ-007 in_id  in  ID_W  SHALL carry the tag, returned unchanged on out_id.
REQ-008 rom_addr  out  8  SHALL drive the seed-table address.
REQ-009 rom_data  in  9  SHALL be the combinational seed-table return (0-cycle latency), valued v/512 ≈ 1/d.
REQ-010 out_valid / out_ready  out / in  1 / 1  SHALL form the result handshake.
REQ-011 out_recip / out_id / out_err  out  16 / ID_W / 1  SHALL carry the result 1/d in Q1.15, the tag and the non-normalized flag.
REQ-012 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 States SHALL be IDLE, SEED, MUL1, MUL2, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 On in_valid&&in_ready, d, in_id and the iteration counter (=0) SHALL be registered; the next state SHALL be SEED, or DONE with out_err=1 and out_recip=0 if in_mant[15]=0.
REQ-015 rom_addr SHALL equal d_reg[14:7] at all times (0 after reset).
REQ-016 SEED SHALL load x = {rom_data, 6'b0} (Q1.15) and go to MUL1, or go to DONE if ITERS=0.
REQ-017 MUL1 SHALL compute p = d*x (32 bit) and store t = p[31:15] (17 bit, Q2.15), then go to MUL2.
REQ-018 MUL2 SHALL compute e = (17'h10000 - t) mod 2^17 and q = x*e (33 bit); x_new SHALL be q[30:15], clamped to 16'h8000 if q[32:31]!=0 or q[30:15]>16'h8000.
REQ-019 MUL2 SHALL increment the counter and go to MUL1 if counter+1<ITERS, else go to DONE.
REQ-020 Both multiplies SHALL share one 16x17 unsigned multiplier; only one product is formed per cycle.
REQ-021 In DONE, out_valid=1 and out_recip=x; outputs SHALL stay stable until out_ready; out_valid&&out_ready SHALL return the block to IDLE (in_ready=1 the following cycle, no same-cycle accept).
REQ-022 Latency from the accept edge to out_valid SHALL be 1+2*ITERS cycles for a normalized d (5 at default), and 1 cycle for an error.

Reset
REQ-023 While rst_n=0: state=IDLE; in_ready=1; busy, out_valid, out_err=0; out_recip, out_id, rom_addr, d_reg, x, t and counter=0.
REQ-024 Reset asserted mid-operation SHALL discard the operation with no result issued.

Configuration
REQ-025 Macro PAU_RECIP_ROUND_EN defined: x_new SHALL use q[30:15]+q[14] (round half up) before clamping. Undefined: x_new SHALL use q[30:15] truncated.

Verification
REQ-026 d=16'h8000, ITERS=2: rom_addr=8'h00, x0=16'h7FC0; out_recip=16'h7FFF without the macro, 16'h8000 with it; out_valid 5 cycles after the accept.
REQ-027 d=16'hFFFF, ITERS=2: rom_addr=8'hFF, x0=16'h4000; out_recip=16'h4000 in both builds.
REQ-028 d=16'h4000: out_err=1, out_recip=16'h0000, out_valid 1 cycle after the accept, in_id echoed.
REQ-029 out_ready held low for 10 cycles in DONE: out_* stable, in_ready=0; after the handshake, in_ready=1 on the next cycle.
REQ-030 rst_n pulsed low during MUL2: all outputs immediately at reset values; a new operand with d=16'hB5A3 is accepted after release and drives rom_addr=8'h6B.
